// File: rtl/cnn_fx_pkg.sv
// Shared Q1.15 fixed-point definitions for the CNN layer datapath:
// widths, FSM encoding and the saturate/ReLU helper.
package cnn_fx_pkg;

    localparam int unsigned Q_W   = 16;
    localparam int unsigned SUM_W = 18;

    localparam logic signed [SUM_W-1:0] SUM_Q_MAX = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] SUM_Q_MIN = SUM_W'(-32768);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        POOL = 2'd2,
        DONE = 2'd3
    } fsm_state_e;

    // Clamp an 18-bit exact sum back to Q1.15; ReLU folds into the low clamp.
    function automatic logic [Q_W-1:0] sat_q15(input logic signed [SUM_W-1:0] s,
                                               input logic                    relu_en);
        logic [Q_W-1:0] r;
        if (s > SUM_Q_MAX) begin
            r = 16'h7FFF;
        end else if (relu_en && s[SUM_W-1]) begin
            r = '0;
        end else if (s < SUM_Q_MIN) begin
            r = 16'h8000;
        end else begin
            r = s[Q_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/max4_q15.sv
// Combinational signed maximum of four Q1.15 values (one 2x2 pooling window).
module max4_q15
    import cnn_fx_pkg::*;
(
    input  logic [Q_W-1:0] i_a,
    input  logic [Q_W-1:0] i_b,
    input  logic [Q_W-1:0] i_c,
    input  logic [Q_W-1:0] i_d,
    output logic [Q_W-1:0] o_max_c
);

    logic [Q_W-1:0] w_ab;
    logic [Q_W-1:0] w_cd;

    assign w_ab    = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
    assign w_cd    = ($signed(i_c) > $signed(i_d)) ? i_c : i_d;
    assign o_max_c = ($signed(w_ab) > $signed(w_cd)) ? w_ab : w_cd;

endmodule

// File: rtl/partial_fm_relu_pool.sv
// Sums three partial feature maps plus bias with saturation/ReLU into a local buffer,
// then 2x2/stride-2 max-pools it, one element per cycle in each phase.
module partial_fm_relu_pool
    import cnn_fx_pkg::*;
#(
    parameter  int unsigned op_size   = 4,
    parameter  bit          relu_en   = 1'b1,
    localparam int unsigned pool_size = op_size / 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                fm_ready,
    input  logic [Q_W-1:0]                      bias,
    input  logic [Q_W*op_size*op_size-1:0]      IK1f,
    input  logic [Q_W*op_size*op_size-1:0]      IK2f,
    input  logic [Q_W*op_size*op_size-1:0]      IK3f,
    output logic                                busy,
    output logic                                done,
    output logic [Q_W*pool_size*pool_size-1:0]  POOLf
);

    localparam int unsigned NFM   = op_size * op_size;
    localparam int unsigned NPOOL = pool_size * pool_size;
    localparam int unsigned K_W   = $clog2(NFM);
    localparam int unsigned PX_W  = (pool_size > 1) ? $clog2(pool_size) : 1;
    localparam int unsigned P_W   = (NPOOL > 1) ? $clog2(NPOOL) : 1;

    fsm_state_e                   r_state;
    fsm_state_e                   w_state_nxt;
    logic [K_W-1:0]               r_k;
    logic [PX_W-1:0]              r_px;
    logic [PX_W-1:0]              r_py;
    logic [Q_W-1:0]               r_bias;
    logic [Q_W-1:0]               r_fm [NFM];
    logic [Q_W*NPOOL-1:0]         r_pool;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_fm_ready_d;

    logic                         w_start;
    logic                         w_k_last;
    logic                         w_p_last;
    logic signed [SUM_W-1:0]      w_sum;
    logic [Q_W-1:0]               w_fm_val;
    logic [K_W-1:0]               w_idx_a;
    logic [K_W-1:0]               w_idx_b;
    logic [K_W-1:0]               w_idx_c;
    logic [K_W-1:0]               w_idx_d;
    logic [P_W-1:0]               w_p;
    logic [Q_W-1:0]               w_max;

    assign w_start  = fm_ready & ~r_fm_ready_d;
    assign w_k_last = (r_k == K_W'(NFM - 1));
    assign w_p_last = (r_px == PX_W'(pool_size - 1)) && (r_py == PX_W'(pool_size - 1));

    // Exact 18-bit sum of the three partial maps and the latched bias at element k.
    assign w_sum = SUM_W'($signed(IK1f[Q_W*r_k +: Q_W]))
                 + SUM_W'($signed(IK2f[Q_W*r_k +: Q_W]))
                 + SUM_W'($signed(IK3f[Q_W*r_k +: Q_W]))
                 + SUM_W'($signed(r_bias));
    assign w_fm_val = sat_q15(w_sum, relu_en);

    // Top-left corner of the pooling window; the others are +1 column / +1 row.
    assign w_idx_a = K_W'(2 * op_size * r_px + 2 * r_py);
    assign w_idx_b = w_idx_a + K_W'(1);
    assign w_idx_c = w_idx_a + K_W'(op_size);
    assign w_idx_d = w_idx_c + K_W'(1);
    assign w_p     = P_W'(r_px * pool_size + r_py);

    max4_q15 u_max4 (
        .i_a     (r_fm[w_idx_a]),
        .i_b     (r_fm[w_idx_b]),
        .i_c     (r_fm[w_idx_c]),
        .i_d     (r_fm[w_idx_d]),
        .o_max_c (w_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)  w_state_nxt = SUM;
            SUM:     if (w_k_last) w_state_nxt = POOL;
            POOL:    if (w_p_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k          <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_bias       <= '0;
            r_pool       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fm_ready_d <= 1'b0;
            for (int i = 0; i < int'(NFM); i++) begin
                r_fm[i] <= '0;
            end
        end else begin
            r_fm_ready_d <= fm_ready;
            r_busy       <= (w_state_nxt == SUM) || (w_state_nxt == POOL);
            r_done       <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_k    <= '0;
                        r_bias <= bias;
                    end
                end
                SUM: begin
                    r_fm[r_k] <= w_fm_val;
                    r_k       <= w_k_last ? '0 : r_k + K_W'(1);
                    r_px      <= '0;
                    r_py      <= '0;
                end
                POOL: begin
                    r_pool[Q_W*w_p +: Q_W] <= w_max;
                    if (r_py == PX_W'(pool_size - 1)) begin
                        r_py <= '0;
                        r_px <= r_px + PX_W'(1);
                    end else begin
                        r_py <= r_py + PX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign POOLf = r_pool;

endmodule

// File: tb/tb_partial_fm_relu_pool.sv
// Directed bench for partial_fm_relu_pool (op_size=4): ReLU and low-clamp instances
// share all inputs; pooled results are captured on the done pulse.
module tb_partial_fm_relu_pool;

    localparam int unsigned OPS = 4;
    localparam int unsigned NFM = OPS * OPS;

    logic              clk;
    logic              rst;
    logic              fm_ready;
    logic [15:0]       bias;
    logic [16*NFM-1:0] ik1;
    logic [16*NFM-1:0] ik2;
    logic [16*NFM-1:0] ik3;
    logic              busy0;
    logic              done0;
    logic [63:0]       pool0;
    logic              busy1;
    logic              done1;
    logic [63:0]       pool1;

    int n_checks = 0;
    int n_errors = 0;

    partial_fm_relu_pool #(.op_size(OPS), .relu_en(1'b1)) dut0 (
        .clk(clk), .rst(rst), .fm_ready(fm_ready), .bias(bias),
        .IK1f(ik1), .IK2f(ik2), .IK3f(ik3),
        .busy(busy0), .done(done0), .POOLf(pool0)
    );

    partial_fm_relu_pool #(.op_size(OPS), .relu_en(1'b0)) dut1 (
        .clk(clk), .rst(rst), .fm_ready(fm_ready), .bias(bias),
        .IK1f(ik1), .IK2f(ik2), .IK3f(ik3),
        .busy(busy1), .done(done1), .POOLf(pool1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16*NFM-1:0] fill(input logic [15:0] v);
        logic [16*NFM-1:0] r;
        for (int i = 0; i < int'(NFM); i++) r[16*i +: 16] = v;
        return r;
    endfunction

    // Raise fm_ready at the current negedge and observe cycles 1..21 after the start edge.
    // mode 0: drop fm_ready in cycle 2; mode 1: keep it high with a low/high blip in POOL.
    task automatic run_pool(input string tag, input logic [63:0] exp0,
                            input logic [63:0] exp1, input int mode);
        int busy_cnt  = 0;
        int done_cnt  = 0;
        int done1_cnt = 0;
        int done_cyc  = -1;
        logic [63:0] cap0 = '0;
        logic [63:0] cap1 = '0;
        fm_ready = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (mode == 0 && c == 2)  fm_ready = 1'b0;
            if (mode == 1 && c == 17) fm_ready = 1'b0;
            if (mode == 1 && c == 18) fm_ready = 1'b1;
            if (busy0) busy_cnt++;
            if (done1) done1_cnt++;
            if (done0) begin
                done_cnt++;
                done_cyc = c;
                cap0 = pool0;
                cap1 = pool1;
            end
            if (c == 1)  check({tag, " busy@1"}, 64'(busy0), 64'd1);
            if (c == 20) check({tag, " busy@20"}, 64'(busy0), 64'd1);
        end
        check({tag, " done_cycle"}, 64'(done_cyc), 64'd21);
        check({tag, " done_count"}, 64'(done_cnt), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd20);
        check({tag, " done_count_lowclamp"}, 64'(done1_cnt), 64'd1);
        check({tag, " pool_relu"}, cap0, exp0);
        check({tag, " pool_lowclamp"}, cap1, exp1);
    endtask

    initial begin
        int extra_done;
        rst      = 1'b1;
        fm_ready = 1'b0;
        bias     = '0;
        ik1      = '0;
        ik2      = '0;
        ik3      = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy0), 64'd0);
        check("reset done", 64'(done0), 64'd0);
        check("reset pool", pool0, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Plain sum: 3 * 0x0800 = 0x1800 everywhere.
        ik1 = fill(16'h0800); ik2 = fill(16'h0800); ik3 = fill(16'h0800); bias = 16'h0000;
        run_pool("t1", 64'h1800_1800_1800_1800, 64'h1800_1800_1800_1800, 0);
        repeat (2) @(negedge clk);

        // Positive saturation.
        ik1 = fill(16'h7FFF); ik2 = fill(16'h7FFF); ik3 = fill(16'h7FFF); bias = 16'h7FFF;
        run_pool("t2_sat", 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 0);
        repeat (2) @(negedge clk);

        // Negative: ReLU gives 0, low clamp gives 0x8000.
        ik1 = fill(16'h8000); ik2 = fill(16'h8000); ik3 = fill(16'h8000); bias = 16'h0000;
        run_pool("t2_neg", 64'h0000_0000_0000_0000, 64'h8000_8000_8000_8000, 0);
        repeat (2) @(negedge clk);

        // Ramp minus 0x100: fm[k] = (k-1)*0x100, windows {0,1,4,5},{2,3,6,7},{8,9,12,13},{10,11,14,15}.
        for (int k = 0; k < int'(NFM); k++) ik1[16*k +: 16] = 16'(k * 256);
        ik2 = '0; ik3 = '0; bias = 16'hFF00;
        run_pool("t3", 64'h0E00_0C00_0600_0400, 64'h0E00_0C00_0600_0400, 0);
        repeat (2) @(negedge clk);

        // Level held high plus a second edge during POOL: only one run.
        ik1 = fill(16'h0100); ik2 = fill(16'h0200); ik3 = fill(16'h0300); bias = 16'h0010;
        run_pool("t4", 64'h0610_0610_0610_0610, 64'h0610_0610_0610_0610, 1);
        extra_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done0) extra_done++;
        end
        check("t4 no_requeue", 64'(extra_done), 64'd0);
        fm_ready = 1'b0;
        @(negedge clk);
        ik1 = fill(16'h0100); ik2 = fill(16'h0100); ik3 = fill(16'h0100); bias = 16'h0000;
        run_pool("t4_new", 64'h0300_0300_0300_0300, 64'h0300_0300_0300_0300, 0);
        repeat (2) @(negedge clk);

        // Reset in cycle 10 of a run aborts it.
        ik1 = fill(16'h0400); ik2 = fill(16'h0000); ik3 = fill(16'h0000); bias = 16'h0000;
        fm_ready = 1'b1;
        extra_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) fm_ready = 1'b0;
            if (done0) extra_done++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5 busy_after_rst", 64'(busy0), 64'd0);
        check("t5 pool_after_rst", pool0, 64'd0);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done0) extra_done++;
        end
        check("t5 no_done", 64'(extra_done), 64'd0);
        run_pool("t5_fresh", 64'h0400_0400_0400_0400, 64'h0400_0400_0400_0400, 0);

        // Back-to-back: new inputs on the done cycle, new edge on the next cycle.
        ik1 = fill(16'h0123); ik2 = fill(16'h0000); ik3 = fill(16'h0000); bias = 16'h0001;
        @(negedge clk);
        run_pool("t6", 64'h0124_0124_0124_0124, 64'h0124_0124_0124_0124, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
